// File: rtl/id_wb_arbiter_pkg.sv
// rtl/id_wb_arbiter_pkg.sv - shared writeback request types for the regfile write-port arbiter
package RV32I_definitions;

    localparam int REG_DATA_WIDTH     = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [REGFILE_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0]     data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } wb_grant_e;

endpackage

// File: rtl/id_wb_arbiter_fifo.sv
// rtl/id_wb_arbiter_fifo.sv - synchronous FIFO of writeback requests
// Exposes every slot plus a valid vector so the owner can decode which registers are pending.
module wb_fifo
    import RV32I_definitions::*;
#(
    parameter type req_t = wb_req_t,
    parameter int  DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  req_t                 push_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output req_t                 head,
    output logic [DEPTH-1:0]     entry_valid,
    output req_t [DEPTH-1:0]     entries
);

    localparam int PW = $clog2(DEPTH);

    req_t [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PW-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/id_wb_arbiter.sv
// rtl/id_wb_arbiter.sv - shares the regfile write port between pipeline writeback (A) and a
// buffered long-latency unit (B), with bounded starvation and a pending-register busy mask.
module id_wb_arbiter
    import RV32I_definitions::*;
#(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int REGFILE_DEPTH      = 32,
    parameter int B_FIFO_DEPTH       = 2,
    parameter int MAX_DEFER          = 3
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          A_valid,
    output logic                          A_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] A_rd_addr,
    input  logic [REG_DATA_WIDTH-1:0]     A_rd_data,
    input  logic                          B_valid,
    output logic                          B_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] B_rd_addr,
    input  logic [REG_DATA_WIDTH-1:0]     B_rd_data,
    output logic                          Rd_wr_en,
    output logic [REGFILE_ADDR_WIDTH-1:0] Rd_addr,
    output logic [REG_DATA_WIDTH-1:0]     Rd_wr_data,
    output logic [REGFILE_DEPTH-1:0]      Busy_mask
);

    localparam int CW = $clog2(MAX_DEFER + 1);

    typedef struct packed {
        logic [REGFILE_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0]     data;
    } req_t;

    req_t                    b_req;
    req_t                    head;
    req_t                    wr;
    req_t [B_FIFO_DEPTH-1:0] entries;
    logic [B_FIFO_DEPTH-1:0] entry_valid;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    force_b;
    logic [CW-1:0]           defer_cnt;
    wb_grant_e               grant;

    assign b_req.addr = B_rd_addr;
    assign b_req.data = B_rd_data;

    assign B_ready = !Reset && !full;
    assign push    = B_valid && B_ready;
    assign force_b = !empty && (defer_cnt == CW'(MAX_DEFER));
    assign A_ready = !Reset && !force_b;
    assign pop     = (grant == GNT_B);

    wb_fifo #(
        .req_t (req_t),
        .DEPTH (B_FIFO_DEPTH)
    ) u_fifo (
        .clk         (Clk),
        .reset       (Reset),
        .push        (push),
        .push_data   (b_req),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .head        (head),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    always_comb begin
        grant = GNT_NONE;
        if (Reset) begin
            grant = GNT_NONE;
        end else if (force_b) begin
            grant = GNT_B;
        end else if (A_valid) begin
            grant = GNT_A;
        end else if (!empty) begin
            grant = GNT_B;
        end
    end

    // Writes to x0 are still consumed by the grant but never reach the regfile.
    always_comb begin
        wr = '0;
        if (grant == GNT_A) begin
            wr.addr = A_rd_addr;
            wr.data = A_rd_data;
        end else if (grant == GNT_B) begin
            wr = head;
        end
        Rd_wr_en   = (grant != GNT_NONE) && (wr.addr != '0);
        Rd_addr    = Rd_wr_en ? wr.addr : '0;
        Rd_wr_data = Rd_wr_en ? wr.data : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            defer_cnt <= '0;
        end else if (empty || pop) begin
            defer_cnt <= '0;
        end else if (grant == GNT_A && defer_cnt != CW'(MAX_DEFER)) begin
            defer_cnt <= defer_cnt + 1'b1;
        end
    end

    always_comb begin
        Busy_mask = '0;
        if (!Reset) begin
            for (int i = 0; i < B_FIFO_DEPTH; i++) begin
                if (entry_valid[i] && entries[i].addr != '0) begin
                    Busy_mask[entries[i].addr] = 1'b1;
                end
            end
        end
    end

endmodule
